// File: rtl/rx_fifo_ctrl.sv
// rx_fifo_ctrl
//   Receive-side buffer between the UART receive engine and the host bus.
//   It captures each completed byte with its error flags, acknowledges the
//   engine with a one-cycle strobe, and presents a first-word-fall-through
//   queue to the host.
//
// Ports
//   Clk           system clock, rising edge
//   Rst           synchronous active-low reset
//   rx_data       received byte from the engine
//   rx_rdy        engine byte ready, held until acknowledged
//   rx_p_err      parity error for rx_data
//   rx_frm_err    framing error for rx_data
//   rx_ov_err     engine overrun, a byte was lost before this one
//   rx_rd_strb    one-cycle acknowledge back to the engine
//   host_rd       pop the head entry, ignored while empty
//   host_data     head entry data, valid while empty=0
//   host_err      head entry flags {ov,frm,p}, valid while empty=0
//   empty         no entries
//   full          count == DEPTH
//   almost_full   count >= AF_LEVEL
//   count         number of entries, 0..DEPTH
//
// Capture FSM
//   state  | meaning
//   S_IDLE | waiting for rx_rdy; captures when not full
//   S_WAIT | byte captured; waiting for the engine to drop rx_rdy
module rx_fifo_ctrl #(
    parameter int DEPTH    = 16,
    parameter int AW       = 4,
    parameter int AF_LEVEL = 12
) (
    input  logic          Clk,
    input  logic          Rst,
    input  logic [7:0]    rx_data,
    input  logic          rx_rdy,
    input  logic          rx_p_err,
    input  logic          rx_frm_err,
    input  logic          rx_ov_err,
    output logic          rx_rd_strb,
    input  logic          host_rd,
    output logic [7:0]    host_data,
    output logic [2:0]    host_err,
    output logic          empty,
    output logic          full,
    output logic          almost_full,
    output logic [AW:0]   count
);

    typedef enum logic {
        S_IDLE = 1'b0,
        S_WAIT = 1'b1
    } state_t;

    localparam logic [AW:0]   DEPTH_CNT = (AW+1)'(DEPTH);
    localparam logic [AW:0]   AF_CNT    = (AW+1)'(AF_LEVEL);
    localparam logic [AW:0]   CNT_ONE   = (AW+1)'(1);
    localparam logic [AW-1:0] PTR_ONE   = AW'(1);

    state_t        state_q, state_d;
    logic [AW-1:0] wptr_q, wptr_d;
    logic [AW-1:0] rptr_q, rptr_d;
    logic [AW:0]   count_q, count_d;
    logic          strb_q, strb_d;
    logic          wr_en, rd_en;
    logic [10:0]   head_entry;

    // Storage is deliberately left out of reset; stale entries are never
    // visible because the pointers and count are cleared.
    logic [10:0]   mem_q [DEPTH];

    // State register
    always_ff @(posedge Clk) begin
        if (!Rst) begin
            state_q <= S_IDLE;
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
            strb_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            count_q <= count_d;
            strb_q  <= strb_d;
        end
    end

    always_ff @(posedge Clk) begin
        if (wr_en) begin
            mem_q[wptr_q] <= {rx_ov_err, rx_frm_err, rx_p_err, rx_data};
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: if (rx_rdy && !full) state_d = S_WAIT;
            S_WAIT: if (!rx_rdy)         state_d = S_IDLE;
            default:                     state_d = S_IDLE;
        endcase
    end

    // Output / datapath logic. full comes from the registered count, so a
    // read while full only frees the slot for the following edge.
    always_comb begin
        wr_en   = (state_q == S_IDLE) && rx_rdy && !full;
        rd_en   = host_rd && !empty;
        strb_d  = wr_en;
        wptr_d  = wr_en ? (wptr_q + PTR_ONE) : wptr_q;
        rptr_d  = rd_en ? (rptr_q + PTR_ONE) : rptr_q;
        count_d = count_q;
        case ({wr_en, rd_en})
            2'b10:   count_d = count_q + CNT_ONE;
            2'b01:   count_d = count_q - CNT_ONE;
            default: count_d = count_q;
        endcase
    end

    assign empty       = (count_q == '0);
    assign full        = (count_q == DEPTH_CNT);
    assign almost_full = (count_q >= AF_CNT);
    assign count       = count_q;
    assign rx_rd_strb  = strb_q;

    assign head_entry  = mem_q[rptr_q];
    assign host_data   = head_entry[7:0];
    assign host_err    = head_entry[10:8];

endmodule

// File: tb/tb_rx_fifo_ctrl.sv
module tb_rx_fifo_ctrl;

    logic       Clk = 1'b0;
    logic       Rst = 1'b0;
    logic [7:0] rx_data = 8'h00;
    logic       rx_rdy = 1'b0;
    logic       rx_p_err = 1'b0;
    logic       rx_frm_err = 1'b0;
    logic       rx_ov_err = 1'b0;
    logic       rx_rd_strb;
    logic       host_rd = 1'b0;
    logic [7:0] host_data;
    logic [2:0] host_err;
    logic       empty;
    logic       full;
    logic       almost_full;
    logic [4:0] count;

    int vectors = 0;
    int miscompares = 0;

    logic [10:0] sb[$];

    rx_fifo_ctrl #(.DEPTH(16), .AW(4), .AF_LEVEL(12)) dut (
        .Clk         (Clk),
        .Rst         (Rst),
        .rx_data     (rx_data),
        .rx_rdy      (rx_rdy),
        .rx_p_err    (rx_p_err),
        .rx_frm_err  (rx_frm_err),
        .rx_ov_err   (rx_ov_err),
        .rx_rd_strb  (rx_rd_strb),
        .host_rd     (host_rd),
        .host_data   (host_data),
        .host_err    (host_err),
        .empty       (empty),
        .full        (full),
        .almost_full (almost_full),
        .count       (count)
    );

    always #5 Clk = ~Clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout, required completion");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic       rst;
        logic       rdy;
        logic [7:0] data;
        logic [2:0] flags;
        logic       rd;
        logic       e_strb;
        logic       e_empty;
        logic       e_full;
        logic       e_af;
        int         e_cnt;
        logic       chk_head;
        logic [7:0] e_data;
        logic [2:0] e_err;
    } vec_t;

    vec_t vecs[15];

    function automatic vec_t mk(input logic rst, input logic rdy, input logic [7:0] data,
                                input logic [2:0] flags, input logic rd, input logic e_strb,
                                input logic e_empty, input logic e_full, input logic e_af,
                                input int e_cnt, input logic chk_head, input logic [7:0] e_data,
                                input logic [2:0] e_err);
        vec_t v;
        v.rst = rst;       v.rdy = rdy;         v.data = data;
        v.flags = flags;   v.rd = rd;           v.e_strb = e_strb;
        v.e_empty = e_empty; v.e_full = e_full; v.e_af = e_af;
        v.e_cnt = e_cnt;   v.chk_head = chk_head;
        v.e_data = e_data; v.e_err = e_err;
        return v;
    endfunction

    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    task automatic chk(input string name, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic [7:0] d, input logic [2:0] f);
        rx_data = d;
        {rx_ov_err, rx_frm_err, rx_p_err} = f;
    endtask

    // Engine model: present a byte, hold rx_rdy until the strobe, then drop it.
    task automatic push_byte(input logic [7:0] d, input logic [2:0] f);
        logic got;
        drive(d, f);
        rx_rdy = 1'b1;
        sb.push_back({f, d});
        got = 1'b0;
        for (int i = 0; i < 20 && !got; i++) begin
            step();
            if (rx_rd_strb) got = 1'b1;
        end
        chk("push_strobe", int'(got), 1);
        rx_rdy = 1'b0;
        step();
    endtask

    task automatic pop_check();
        logic [10:0] e;
        if (sb.size() == 0) begin
            chk("pop_sb_nonempty", 0, 1);
        end else begin
            e = sb.pop_front();
            chk("pop_empty", int'(empty), 0);
            chk("pop_data", int'(host_data), int'(e[7:0]));
            chk("pop_err", int'(host_err), int'(e[10:8]));
            host_rd = 1'b1;
            step();
            host_rd = 1'b0;
        end
    endtask

    initial begin
        int sent, mcnt, nstrb, cyc, maxcnt;
        logic pop_pend;
        logic [10:0] e;

        //       rst rdy data   fl rd  strb emp ful af cnt chk data   err
        vecs[0]  = mk(0, 0, 8'h00, 0, 0,  0,  1,  0,  0, 0,  0, 8'h00, 0);
        vecs[1]  = mk(0, 0, 8'h00, 0, 0,  0,  1,  0,  0, 0,  0, 8'h00, 0);
        vecs[2]  = mk(1, 1, 8'hA5, 0, 0,  1,  0,  0,  0, 1,  1, 8'hA5, 0);
        vecs[3]  = mk(1, 1, 8'hA5, 0, 0,  0,  0,  0,  0, 1,  1, 8'hA5, 0);
        vecs[4]  = mk(1, 0, 8'hA5, 0, 0,  0,  0,  0,  0, 1,  1, 8'hA5, 0);
        vecs[5]  = mk(1, 0, 8'h00, 0, 1,  0,  1,  0,  0, 0,  0, 8'h00, 0);
        vecs[6]  = mk(1, 1, 8'h3C, 2, 0,  1,  0,  0,  0, 1,  1, 8'h3C, 2);
        vecs[7]  = mk(1, 0, 8'h3C, 2, 0,  0,  0,  0,  0, 1,  1, 8'h3C, 2);
        vecs[8]  = mk(1, 1, 8'h7E, 1, 0,  1,  0,  0,  0, 2,  1, 8'h3C, 2);
        vecs[9]  = mk(1, 0, 8'h7E, 1, 1,  0,  0,  0,  0, 1,  1, 8'h7E, 1);
        vecs[10] = mk(1, 0, 8'h00, 0, 1,  0,  1,  0,  0, 0,  0, 8'h00, 0);
        vecs[11] = mk(1, 1, 8'h55, 4, 1,  1,  0,  0,  0, 1,  1, 8'h55, 4);
        vecs[12] = mk(1, 0, 8'h55, 4, 0,  0,  0,  0,  0, 1,  1, 8'h55, 4);
        vecs[13] = mk(1, 1, 8'h66, 0, 1,  1,  0,  0,  0, 1,  1, 8'h66, 0);
        vecs[14] = mk(1, 0, 8'h00, 0, 1,  0,  1,  0,  0, 0,  0, 8'h00, 0);

        // Reset, single byte, error flags, read-while-empty, same-cycle read+write
        for (int i = 0; i < 15; i++) begin
            Rst     = vecs[i].rst;
            rx_rdy  = vecs[i].rdy;
            host_rd = vecs[i].rd;
            drive(vecs[i].data, vecs[i].flags);
            step();
            chk($sformatf("vec%0d_strb", i),  int'(rx_rd_strb),  int'(vecs[i].e_strb));
            chk($sformatf("vec%0d_empty", i), int'(empty),       int'(vecs[i].e_empty));
            chk($sformatf("vec%0d_full", i),  int'(full),        int'(vecs[i].e_full));
            chk($sformatf("vec%0d_af", i),    int'(almost_full), int'(vecs[i].e_af));
            chk($sformatf("vec%0d_count", i), int'(count),       vecs[i].e_cnt);
            if (vecs[i].chk_head) begin
                chk($sformatf("vec%0d_data", i), int'(host_data), int'(vecs[i].e_data));
                chk($sformatf("vec%0d_err", i),  int'(host_err),  int'(vecs[i].e_err));
            end
        end
        rx_rdy  = 1'b0;
        host_rd = 1'b0;
        step();

        // Fill to full, backpressure, read frees one slot
        for (int k = 0; k < 16; k++) begin
            push_byte(8'(k), 3'b000);
            chk($sformatf("fill%0d_count", k), int'(count), k + 1);
            chk($sformatf("fill%0d_af", k), int'(almost_full), (k + 1 >= 12) ? 1 : 0);
        end
        chk("fill_full", int'(full), 1);
        drive(8'h10, 3'b000);
        rx_rdy = 1'b1;
        sb.push_back({3'b000, 8'h10});
        for (int k = 0; k < 3; k++) begin
            step();
            chk("bp_no_strobe", int'(rx_rd_strb), 0);
            chk("bp_count", int'(count), 16);
        end
        pop_check();
        chk("rdfull_count", int'(count), 15);
        chk("rdfull_full", int'(full), 0);
        chk("rdfull_no_same_edge", int'(rx_rd_strb), 0);
        step();
        chk("refill_strobe", int'(rx_rd_strb), 1);
        chk("refill_count", int'(count), 16);
        chk("refill_full", int'(full), 1);
        rx_rdy = 1'b0;
        step();
        while (sb.size() > 0) pop_check();
        chk("drain_empty", int'(empty), 1);

        // Randomised concurrency and wrap
        sent = 0; mcnt = 0; nstrb = 0; cyc = 0; maxcnt = 0;
        pop_pend = 1'b0;
        while (cyc < 3000 && (sent < 40 || mcnt > 0 || rx_rdy)) begin
            step();
            cyc++;
            if (pop_pend) mcnt--;
            if (rx_rd_strb) begin
                mcnt++;
                nstrb++;
                rx_rdy = 1'b0;
            end else if (!rx_rdy && sent < 40 && $urandom_range(0, 99) < 60) begin
                drive(8'(sent * 7 + 3), 3'(sent));
                sb.push_back({3'(sent), 8'(sent * 7 + 3)});
                rx_rdy = 1'b1;
                sent++;
            end
            chk("mix_count", int'(count), mcnt);
            if (int'(count) > maxcnt) maxcnt = int'(count);
            pop_pend = 1'b0;
            host_rd  = 1'b0;
            if (mcnt > 0 && sb.size() > 0 &&
                $urandom_range(0, 99) < ((cyc < 120) ? 25 : 70)) begin
                e = sb.pop_front();
                chk("mix_data", int'(host_data), int'(e[7:0]));
                chk("mix_err", int'(host_err), int'(e[10:8]));
                host_rd  = 1'b1;
                pop_pend = 1'b1;
            end
        end
        host_rd = 1'b0;
        rx_rdy  = 1'b0;
        step();
        chk("mix_done", (sent == 40 && mcnt == 0) ? 1 : 0, 1);
        chk("mix_strobes", nstrb, 40);
        chk("mix_sb_left", sb.size(), 0);
        chk("mix_max_le_16", (maxcnt <= 16) ? 1 : 0, 1);
        chk("mix_empty", int'(empty), 1);

        // Reset while in WAIT with five entries
        for (int k = 0; k < 4; k++) push_byte(8'(8'h80 + k), 3'b000);
        drive(8'h84, 3'b000);
        sb.push_back({3'b000, 8'h84});
        rx_rdy = 1'b1;
        step();
        chk("prerst_strobe", int'(rx_rd_strb), 1);
        chk("prerst_count", int'(count), 5);
        Rst = 1'b0;
        step();
        sb.delete();
        chk("rst_count", int'(count), 0);
        chk("rst_empty", int'(empty), 1);
        chk("rst_full", int'(full), 0);
        chk("rst_strobe", int'(rx_rd_strb), 0);
        Rst = 1'b1;
        drive(8'hC3, 3'b101);
        sb.push_back({3'b101, 8'hC3});
        step();
        chk("postrst_strobe", int'(rx_rd_strb), 1);
        chk("postrst_count", int'(count), 1);
        rx_rdy = 1'b0;
        step();
        pop_check();
        chk("postrst_empty", int'(empty), 1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
